tx_frame_scheduler: RTL

//  Sequences the 16-QAM transmit datapath one frame at a time: preamble, payload symbols pulled from a source, then a guard interval.

---
 rtl/tx_frame_scheduler.sv | 100 ++++++++++
 1 files changed

// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: frames 16-QAM symbols as preamble, sourced payload and guard, one symbol every SPS clocks.
module tx_frame_scheduler #(
  parameter int SPS          = 8,
  parameter int PREAMBLE_LEN = 32,
  parameter int GUARD_LEN    = 16,
  parameter int LEN_W        = 9
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             START,
  input  logic [LEN_W-1:0] FRAME_LEN,
  input  logic             ABORT,
  input  logic [3:0]       SRC_DATA,
  input  logic             SRC_VALID,
  output logic             SRC_READY,
  output logic [3:0]       SYM_DATA,
  output logic             SYM_STROBE,
  output logic             TX_ACTIVE,
  output logic             BUSY,
  output logic             DONE,
  output logic             UNDERRUN
);
  localparam int PW = SPS > 1 ? $clog2(SPS) : 1;
  localparam int ML = PREAMBLE_LEN > GUARD_LEN ? PREAMBLE_LEN : GUARD_LEN;
  localparam int CW = LEN_W > $clog2(ML + 1) ? LEN_W : $clog2(ML + 1);
  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GUARD} state_t;
  state_t           r_state;
  logic [PW-1:0]    r_phase;
  logic [CW-1:0]    r_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_ready;
  logic             w_last_ph, w_pre_last, w_pay_last, w_grd_last, w_abort, w_pay_next;
  assign w_last_ph  = r_phase == PW'(SPS - 1);
  assign w_pre_last = r_cnt == CW'(PREAMBLE_LEN - 1);
  assign w_pay_last = r_cnt == CW'(r_len) - CW'(1);
  assign w_grd_last = r_cnt == CW'(GUARD_LEN - 1);
  assign w_abort    = (r_state == PAYLOAD) && ABORT;
  // next symbol is a payload slot: fetch it during the current symbol's last cycle
  assign w_pay_next = ((r_state == PREAMBLE) && w_pre_last && (|r_len)) ||
                      ((r_state == PAYLOAD) && !w_pay_last);
  assign SRC_READY  = r_ready & ~w_abort;
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_phase    <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_ready    <= 1'b0;
      SYM_DATA   <= 4'h0;
      SYM_STROBE <= 1'b0;
      TX_ACTIVE  <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      UNDERRUN   <= 1'b0;
    end else begin
      DONE       <= 1'b0;
      SYM_STROBE <= 1'b0;
      r_ready    <= 1'b0;
      if (r_state == IDLE) begin
        if (START) begin
          r_state    <= PREAMBLE;
          r_phase    <= '0;
          r_cnt      <= '0;
          r_len      <= FRAME_LEN;
          UNDERRUN   <= 1'b0;
          SYM_STROBE <= 1'b1;
          SYM_DATA   <= 4'h0;
          TX_ACTIVE  <= 1'b1;
          BUSY       <= 1'b1;
        end
      end else if (!w_last_ph) begin
        r_phase <= r_phase + PW'(1);
        r_ready <= (r_phase == PW'(SPS - 2)) && w_pay_next;
      end else begin
        r_phase    <= '0;
        r_cnt      <= r_cnt + CW'(1);
        SYM_STROBE <= 1'b1;
        if ((r_state == PREAMBLE) && !w_pre_last) begin
          SYM_DATA <= {4{~r_cnt[0]}};
        end else if (w_pay_next && !w_abort) begin
          r_state  <= PAYLOAD;
          SYM_DATA <= SRC_VALID ? SRC_DATA : 4'h0;
          if (!SRC_VALID) UNDERRUN <= 1'b1;
          if (r_state == PREAMBLE) r_cnt <= '0;
        end else if (r_state != GUARD) begin
          r_state   <= GUARD;
          r_cnt     <= '0;
          SYM_DATA  <= 4'h0;
          TX_ACTIVE <= 1'b0;
        end else if (w_grd_last) begin
          r_state    <= IDLE;
          r_cnt      <= '0;
          SYM_STROBE <= 1'b0;
          BUSY       <= 1'b0;
          DONE       <= 1'b1;
        end
      end
    end
  end
endmodule
